// File: rtl/ysyx_220066_div_unit_if.sv
// Issue-side and writeback-side signals of the iterative divider.
// master = issue/WB side driving the unit, slave = the divider itself.
interface ysyx_220066_div_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] nxtpc_in;
    logic            error_in;
    logic            flush;
    logic            Div_wen;
    logic [4:0]      Div_rd;
    logic [XLEN-1:0] Div_data;
    logic [XLEN-1:0] Div_nxtpc;
    logic            Div_error;
    logic            div_block;

    modport master (
        output in_valid, op, word, src1, src2, rd_in, nxtpc_in, error_in, flush, div_block,
        input  in_ready, Div_wen, Div_rd, Div_data, Div_nxtpc, Div_error
    );

    modport slave (
        input  in_valid, op, word, src1, src2, rd_in, nxtpc_in, error_in, flush, div_block,
        output in_ready, Div_wen, Div_rd, Div_data, Div_nxtpc, Div_error
    );
endinterface

// File: rtl/ysyx_220066_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Handshake: an op is taken on an edge where in_valid && in_ready; Div_* is held while div_block in DONE.
module ysyx_220066_div_unit #(
    parameter int XLEN = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_220066_div_unit_if.slave       bus,
    output logic [1:0]                  state_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_q_q;
    logic            sign_a_q;
    logic            rem_sel_q;
    logic            word_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] nxtpc_q;
    logic            error_q;
    logic            div_wen_q;
    logic [4:0]      div_rd_q;
    logic [XLEN-1:0] div_data_q;
    logic [XLEN-1:0] div_nxtpc_q;
    logic            div_error_q;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x, input logic w);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    // Operand preparation, evaluated against the incoming op.
    logic            signed_d;
    logic [XLEN-1:0] a_ext_d, b_ext_d, mag_a_d, mag_b_d, min_d, special_d;
    logic            sign_a_d, sign_b_d, div_zero_d, ovf_d;

    always_comb begin
        signed_d   = ~bus.op[0];
        a_ext_d    = bus.word ? {{(XLEN-32){signed_d & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
        b_ext_d    = bus.word ? {{(XLEN-32){signed_d & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
        sign_a_d   = signed_d & a_ext_d[XLEN-1];
        sign_b_d   = signed_d & b_ext_d[XLEN-1];
        mag_a_d    = sign_a_d ? -a_ext_d : a_ext_d;
        mag_b_d    = sign_b_d ? -b_ext_d : b_ext_d;
        min_d      = bus.word ? {{(XLEN-32){1'b1}}, 1'b1, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero_d = (b_ext_d == '0);
        ovf_d      = signed_d && (a_ext_d == min_d) && (b_ext_d == '1);
        special_d  = '0;
        if (div_zero_d) begin
            special_d = bus.op[1] ? sext_w(a_ext_d, bus.word) : '1;
        end else if (ovf_d) begin
            special_d = bus.op[1] ? '0 : min_d;
        end
    end

    // One restoring shift-subtract step.
    logic [XLEN:0]   rem_sh_d;
    logic [XLEN:0]   diff_d;
    logic            ge_d;
    logic [XLEN-1:0] rem_d, quo_d;

    always_comb begin
        rem_sh_d = {rem_q, quo_q[XLEN-1]};
        diff_d   = rem_sh_d - {1'b0, dvs_q};
        ge_d     = (rem_sh_d >= {1'b0, dvs_q});
        rem_d    = ge_d ? diff_d[XLEN-1:0] : rem_sh_d[XLEN-1:0];
        quo_d    = {quo_q[XLEN-2:0], ge_d};
    end

    // Sign fix-up; W quotients live in the low 32 bits of quo_q.
    logic [XLEN-1:0] quo_w_d, q_fix_d, r_fix_d, res_d;

    always_comb begin
        quo_w_d = word_q ? {{(XLEN-32){1'b0}}, quo_q[31:0]} : quo_q;
        q_fix_d = neg_q_q ? -quo_w_d : quo_w_d;
        r_fix_d = sign_a_q ? -rem_q : rem_q;
        res_d   = sext_w(rem_sel_q ? r_fix_d : q_fix_d, word_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_q_q     <= 1'b0;
            sign_a_q    <= 1'b0;
            rem_sel_q   <= 1'b0;
            word_q      <= 1'b0;
            rd_q        <= '0;
            nxtpc_q     <= '0;
            error_q     <= 1'b0;
            div_wen_q   <= 1'b0;
            div_rd_q    <= '0;
            div_data_q  <= '0;
            div_nxtpc_q <= '0;
            div_error_q <= 1'b0;
        end else if (bus.flush) begin
            state_q   <= IDLE;
            div_wen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        rd_q      <= bus.rd_in;
                        nxtpc_q   <= bus.nxtpc_in;
                        error_q   <= bus.error_in;
                        rem_sel_q <= bus.op[1];
                        word_q    <= bus.word;
                        if (div_zero_d || ovf_d) begin
                            div_wen_q   <= 1'b1;
                            div_data_q  <= special_d;
                            div_rd_q    <= bus.rd_in;
                            div_nxtpc_q <= bus.nxtpc_in;
                            div_error_q <= bus.error_in;
                            state_q     <= DONE;
                        end else begin
                            rem_q    <= '0;
                            quo_q    <= bus.word ? {mag_a_d[31:0], 32'b0} : mag_a_d;
                            dvs_q    <= mag_b_d;
                            neg_q_q  <= sign_a_d ^ sign_b_d;
                            sign_a_q <= sign_a_d;
                            cnt_q    <= bus.word ? CW'(32) : CW'(XLEN);
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    div_wen_q   <= 1'b1;
                    div_data_q  <= res_d;
                    div_rd_q    <= rd_q;
                    div_nxtpc_q <= nxtpc_q;
                    div_error_q <= error_q;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (!bus.div_block) begin
                        div_wen_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.Div_wen   = div_wen_q;
    assign bus.Div_rd    = div_rd_q;
    assign bus.Div_data  = div_data_q;
    assign bus.Div_nxtpc = div_nxtpc_q;
    assign bus.Div_error = div_error_q;
    assign state_o       = state_q;
endmodule
